bp_cce_mshr_bank: RTL and testbench
===================================

BP_CCE_MSHR_BANK -- requirements
Module: bp_cce_mshr_bank

Interface
REQ-001 Param num_mshr_p, default 4: number of MSHR entries (1..16).
REQ-002 Param gpr_num_p, default 8: number of shared GPRs.
REQ-003 Param gpr_width_p, default 64: GPR and source-operand width.
REQ-004 Param paddr_width_p, default 40: physical address width.
REQ-005 Param lce_id_width_p, default 4: LCE ID width.
REQ-006 Param num_flags_p, default 16: flag bits per entry.
REQ-007 The module SHALL have one clock and a synchronous active-low reset, with ports as follows.
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- stall_i  in  1  microcode stall; blocks all ucode-initiated writes.
- alloc_v_i  in  1  allocation request.
- alloc_lce_id_i  in  lce_id_width_p  requesting LCE.
- alloc_paddr_i  in  paddr_width_p  request address.
- alloc_flags_i  in  num_flags_p  initial flags.
- alloc_ready_o  out  1  a free entry exists.
- alloc_id_o  out  clog2(num_mshr_p)  index to be granted.
- sel_id_i  in  clog2(num_mshr_p)  active entry.
- field_w_v_i  in  4  write enables for {lce_id, paddr, way_id, next_coh_state}.
- flag_w_v_i  in  num_flags_p  per-flag write enables.
- src_a_i  in  gpr_width_p  write data.
- release_v_i  in  1  free the active entry.
- gpr_w_mask_i  in  gpr_num_p  GPR write enables.
- dir_addr_v_i  in  1  directory address write (legal while stalled).
- dir_addr_gpr_i  in  clog2(gpr_num_p)  directory destination GPR.
- dir_addr_i  in  paddr_width_p  directory address.
- mshr_o  out  struct  fields of the active entry.
- busy_o  out  num_mshr_p  per-entry busy vector.
- busy_count_o  out  clog2(num_mshr_p+1)  number of busy entries.
- gpr_o  out  gpr_num_p*gpr_width_p  GPR contents.
- err_o  out  1  sticky protocol error.
- perf_block_cnt_o  out  16  count of cycles with allocation blocked.

Function
REQ-008 alloc_ready_o SHALL equal |~busy; alloc_id_o SHALL be the lowest-index free entry.
REQ-009 Allocation fires when alloc_v_i & alloc_ready_o & ~stall_i. On the next edge the entry becomes busy and loads lce_id, paddr and flags from the alloc inputs; way_id and next_coh_state are cleared to 0 (next_coh_state = e_COH_I).
REQ-010 mshr_o SHALL be a combinational read of the registered entry at sel_id_i, with zero added latency.
REQ-011 Field and flag writes SHALL update only the active entry, only when ~stall_i and the entry is busy. Data is taken from the low bits of src_a_i.
REQ-012 A release SHALL clear the entry's busy bit and zero its contents on the next edge when ~stall_i.
REQ-013 A release and an allocation in the same cycle SHALL both complete; a released entry becomes allocatable the following cycle.
REQ-014 Allocation SHALL take priority over field writes when sel_id_i equals alloc_id_o.
REQ-015 When all entries are busy, alloc_v_i SHALL be ignored and no state changes.
REQ-016 A release, field write or flag write targeting a non-busy entry SHALL be dropped and SHALL set err_o. err_o clears only on reset.
REQ-017 GPR writes SHALL follow gpr_w_mask_i when ~stall_i. A dir_addr_v_i write (zero-extended dir_addr_i) SHALL occur regardless of stall and SHALL win over the mask write on the same GPR.
REQ-018 busy_count_o SHALL be registered and SHALL always equal popcount(busy_o).

Reset
REQ-019 While reset_n_i is low at a clock edge, all entries, busy_o, busy_count_o, GPRs, err_o and perf_block_cnt_o SHALL go to 0, and alloc_ready_o SHALL read 1.
REQ-020 Reset asserted mid-operation SHALL abandon all pending allocations and writes.

Configuration
REQ-021 With BP_CCE_MSHR_BANK_PERF_EN defined, perf_block_cnt_o SHALL increment, saturating at 0xFFFF, each cycle alloc_v_i=1 and alloc_ready_o=0.
REQ-022 Without BP_CCE_MSHR_BANK_PERF_EN, perf_block_cnt_o SHALL be tied to 0 and no counter flops SHALL be present.

Structure
REQ-023 The entry struct macro and the field-enable index enum (e_mshr_fld_lce, e_mshr_fld_paddr, e_mshr_fld_way, e_mshr_fld_ncs) SHALL reside in bp_me_pkg.
REQ-024 The free-entry priority encoder and popcount SHALL form one sub-module, bp_cce_mshr_alloc.

Verification
REQ-025 Reset, then allocate 4 times (num_mshr_p=4) -> alloc_id_o = 0,1,2,3; busy_o=4'hF; alloc_ready_o=0.
REQ-026 With the bank full, release entry 2 and assert alloc in the same cycle -> alloc ignored; the next cycle grants id 2 and busy_count_o returns to 4.
REQ-027 With stall_i=1, write paddr 0x1234 and dir_addr_v_i to GPR3=0xABC -> paddr unchanged; GPR3=0xABC.
REQ-028 Field write to non-busy entry 1 -> entry unchanged; err_o=1 and stays 1.
REQ-029 With PERF_EN, hold alloc_v_i high for 10 cycles while full -> perf_block_cnt_o=10; without PERF_EN -> 0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared CCE/ME types: coherence states, MSHR field-enable indices, entry struct macro
`ifndef BP_ME_PKG_SV
`define BP_ME_PKG_SV

`define DECLARE_BP_CCE_MSHR_ENTRY_S(lce_id_width_mp, paddr_width_mp, num_flags_mp) \
  typedef struct packed { \
    logic [lce_id_width_mp-1:0]                lce_id; \
    logic [paddr_width_mp-1:0]                 paddr; \
    logic [bp_me_pkg::mshr_way_width_gp-1:0]   way_id; \
    bp_me_pkg::bp_coh_states_e                 next_coh_state; \
    logic [num_flags_mp-1:0]                   flags; \
  } bp_cce_mshr_entry_s

`define BP_CCE_MSHR_ENTRY_WIDTH(lce_id_width_mp, paddr_width_mp, num_flags_mp) \
  (lce_id_width_mp + paddr_width_mp + bp_me_pkg::mshr_way_width_gp + 3 + num_flags_mp)

package bp_me_pkg;

  localparam int mshr_way_width_gp = 8;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_mshr_fld_lce   = 2'd0,
    e_mshr_fld_paddr = 2'd1,
    e_mshr_fld_way   = 2'd2,
    e_mshr_fld_ncs   = 2'd3
  } bp_cce_mshr_fld_e;

endpackage

`endif

// File: rtl/bp_cce_mshr_alloc.sv
// rtl/bp_cce_mshr_alloc.sv - lowest-free-entry priority encoder and busy popcount for the MSHR bank
module bp_cce_mshr_alloc
  #(parameter int num_mshr_p    = 4,
    parameter int id_width_p    = 2,
    parameter int count_width_p = 3)
  (input  logic [num_mshr_p-1:0]    busy_i,
   input  logic [num_mshr_p-1:0]    busy_next_i,
   output logic                     ready_o,
   output logic [id_width_p-1:0]    id_o,
   output logic [count_width_p-1:0] count_next_o);

  assign ready_o = |(~busy_i);

  // Scan high-to-low so the last hit (lowest index) wins.
  always_comb begin
    id_o = '0;
    for (int i = num_mshr_p-1; i >= 0; i--) begin
      if (!busy_i[i]) id_o = id_width_p'(i);
    end
  end

  always_comb begin
    count_next_o = '0;
    for (int i = 0; i < num_mshr_p; i++) begin
      count_next_o = count_next_o + count_width_p'(busy_next_i[i]);
    end
  end

endmodule

// File: rtl/bp_cce_mshr_bank.sv
// rtl/bp_cce_mshr_bank.sv - CCE MSHR bank with shared GPRs; BP_CCE_MSHR_BANK_PERF_EN adds the alloc-blocked counter
module bp_cce_mshr_bank
  import bp_me_pkg::*;
  #(parameter int num_mshr_p     = 4,
    parameter int gpr_num_p      = 8,
    parameter int gpr_width_p    = 64,
    parameter int paddr_width_p  = 40,
    parameter int lce_id_width_p = 4,
    parameter int num_flags_p    = 16,
    localparam int id_w_lp       = (num_mshr_p > 1) ? $clog2(num_mshr_p) : 1,
    localparam int gpr_id_w_lp   = (gpr_num_p > 1) ? $clog2(gpr_num_p) : 1,
    localparam int count_w_lp    = $clog2(num_mshr_p+1),
    localparam int entry_w_lp    = `BP_CCE_MSHR_ENTRY_WIDTH(lce_id_width_p, paddr_width_p, num_flags_p))
  (input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             stall_i,
   input  logic                             alloc_v_i,
   input  logic [lce_id_width_p-1:0]        alloc_lce_id_i,
   input  logic [paddr_width_p-1:0]         alloc_paddr_i,
   input  logic [num_flags_p-1:0]           alloc_flags_i,
   output logic                             alloc_ready_o,
   output logic [id_w_lp-1:0]               alloc_id_o,
   input  logic [id_w_lp-1:0]               sel_id_i,
   input  logic [3:0]                       field_w_v_i,
   input  logic [num_flags_p-1:0]           flag_w_v_i,
   input  logic [gpr_width_p-1:0]           src_a_i,
   input  logic                             release_v_i,
   input  logic [gpr_num_p-1:0]             gpr_w_mask_i,
   input  logic                             dir_addr_v_i,
   input  logic [gpr_id_w_lp-1:0]           dir_addr_gpr_i,
   input  logic [paddr_width_p-1:0]         dir_addr_i,
   output logic [entry_w_lp-1:0]            mshr_o,
   output logic [num_mshr_p-1:0]            busy_o,
   output logic [count_w_lp-1:0]            busy_count_o,
   output logic [gpr_num_p*gpr_width_p-1:0] gpr_o,
   output logic                             err_o,
   output logic [15:0]                      perf_block_cnt_o);

  `DECLARE_BP_CCE_MSHR_ENTRY_S(lce_id_width_p, paddr_width_p, num_flags_p);

  bp_cce_mshr_entry_s [num_mshr_p-1:0]        entries_r, entries_n;
  logic [num_mshr_p-1:0]                      busy_r, busy_n;
  logic [count_w_lp-1:0]                      count_r, count_n;
  logic [gpr_num_p-1:0][gpr_width_p-1:0]      gpr_r, gpr_n;
  logic                                       err_r, err_n;
  logic                                       sel_busy, ucode_wr, alloc_fire;

  bp_cce_mshr_alloc
    #(.num_mshr_p(num_mshr_p), .id_width_p(id_w_lp), .count_width_p(count_w_lp))
    alloc
     (.busy_i(busy_r),
      .busy_next_i(busy_n),
      .ready_o(alloc_ready_o),
      .id_o(alloc_id_o),
      .count_next_o(count_n));

  assign alloc_fire = alloc_v_i & alloc_ready_o & ~stall_i;
  assign ucode_wr   = release_v_i | (|field_w_v_i) | (|flag_w_v_i);

  // Out-of-range sel_id_i reads as a non-busy, all-zero entry.
  always_comb begin
    sel_busy = 1'b0;
    mshr_o   = '0;
    for (int i = 0; i < num_mshr_p; i++) begin
      if (sel_id_i == id_w_lp'(i)) begin
        sel_busy = busy_r[i];
        mshr_o   = entries_r[i];
      end
    end
  end

  // Release beats field writes on the same entry; allocation lands on a free
  // entry so it never collides with a legal ucode write.
  always_comb begin
    entries_n = entries_r;
    busy_n    = busy_r;
    err_n     = err_r;
    if (~stall_i) begin
      if (ucode_wr && !sel_busy) err_n = 1'b1;
      for (int i = 0; i < num_mshr_p; i++) begin
        if (busy_r[i] && sel_id_i == id_w_lp'(i)) begin
          if (release_v_i) begin
            entries_n[i] = '0;
            busy_n[i]    = 1'b0;
          end else begin
            if (field_w_v_i[e_mshr_fld_lce])   entries_n[i].lce_id = src_a_i[lce_id_width_p-1:0];
            if (field_w_v_i[e_mshr_fld_paddr]) entries_n[i].paddr  = src_a_i[paddr_width_p-1:0];
            if (field_w_v_i[e_mshr_fld_way])   entries_n[i].way_id = src_a_i[mshr_way_width_gp-1:0];
            if (field_w_v_i[e_mshr_fld_ncs])
              entries_n[i].next_coh_state = bp_coh_states_e'(src_a_i[2:0]);
            for (int j = 0; j < num_flags_p; j++) begin
              if (flag_w_v_i[j]) entries_n[i].flags[j] = src_a_i[j];
            end
          end
        end
      end
      if (alloc_fire) begin
        for (int i = 0; i < num_mshr_p; i++) begin
          if (alloc_id_o == id_w_lp'(i)) begin
            entries_n[i].lce_id         = alloc_lce_id_i;
            entries_n[i].paddr          = alloc_paddr_i;
            entries_n[i].way_id         = '0;
            entries_n[i].next_coh_state = e_COH_I;
            entries_n[i].flags          = alloc_flags_i;
            busy_n[i]                   = 1'b1;
          end
        end
      end
    end
  end

  // Directory address writes bypass the stall and override the masked write.
  always_comb begin
    gpr_n = gpr_r;
    if (~stall_i) begin
      for (int g = 0; g < gpr_num_p; g++) begin
        if (gpr_w_mask_i[g]) gpr_n[g] = src_a_i;
      end
    end
    if (dir_addr_v_i) begin
      for (int g = 0; g < gpr_num_p; g++) begin
        if (dir_addr_gpr_i == gpr_id_w_lp'(g)) gpr_n[g] = gpr_width_p'(dir_addr_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      entries_r <= '0;
      busy_r    <= '0;
      count_r   <= '0;
      gpr_r     <= '0;
      err_r     <= 1'b0;
    end else begin
      entries_r <= entries_n;
      busy_r    <= busy_n;
      count_r   <= count_n;
      gpr_r     <= gpr_n;
      err_r     <= err_n;
    end
  end

  assign busy_o       = busy_r;
  assign busy_count_o = count_r;
  assign gpr_o        = gpr_r;
  assign err_o        = err_r;

`ifdef BP_CCE_MSHR_BANK_PERF_EN
  logic [15:0] perf_cnt_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      perf_cnt_r <= '0;
    else if (alloc_v_i && !alloc_ready_o && perf_cnt_r != 16'hFFFF)
      perf_cnt_r <= perf_cnt_r + 16'd1;
  end

  assign perf_block_cnt_o = perf_cnt_r;
`else
  assign perf_block_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_cce_mshr_bank.sv
// tb/tb_bp_cce_mshr_bank.sv - directed self-checking bench for bp_cce_mshr_bank
module tb_bp_cce_mshr_bank;
  import bp_me_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          alloc_v;
  logic [3:0]    alloc_lce_id;
  logic [39:0]   alloc_paddr;
  logic [15:0]   alloc_flags;
  logic          alloc_ready;
  logic [1:0]    alloc_id;
  logic [1:0]    sel_id;
  logic [3:0]    field_w_v;
  logic [15:0]   flag_w_v;
  logic [63:0]   src_a;
  logic          release_v;
  logic [7:0]    gpr_w_mask;
  logic          dir_addr_v;
  logic [2:0]    dir_addr_gpr;
  logic [39:0]   dir_addr;
  logic [70:0]   mshr;
  logic [3:0]    busy;
  logic [2:0]    busy_count;
  logic [511:0]  gpr;
  logic          err;
  logic [15:0]   perf_block_cnt;

  int checks = 0;
  int errors = 0;

`ifdef BP_CCE_MSHR_BANK_PERF_EN
  localparam logic [63:0] perf_exp = 64'd10;
`else
  localparam logic [63:0] perf_exp = 64'd0;
`endif

  bp_cce_mshr_bank dut
    (.clk_i(clk), .reset_n_i(reset_n), .stall_i(stall),
     .alloc_v_i(alloc_v), .alloc_lce_id_i(alloc_lce_id), .alloc_paddr_i(alloc_paddr),
     .alloc_flags_i(alloc_flags), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
     .sel_id_i(sel_id), .field_w_v_i(field_w_v), .flag_w_v_i(flag_w_v), .src_a_i(src_a),
     .release_v_i(release_v), .gpr_w_mask_i(gpr_w_mask), .dir_addr_v_i(dir_addr_v),
     .dir_addr_gpr_i(dir_addr_gpr), .dir_addr_i(dir_addr), .mshr_o(mshr), .busy_o(busy),
     .busy_count_o(busy_count), .gpr_o(gpr), .err_o(err), .perf_block_cnt_o(perf_block_cnt));

  always #5 clk = ~clk;

  function automatic logic [63:0] e_lce();   return 64'(mshr[70:67]); endfunction
  function automatic logic [63:0] e_paddr(); return 64'(mshr[66:27]); endfunction
  function automatic logic [63:0] e_way();   return 64'(mshr[26:19]); endfunction
  function automatic logic [63:0] e_ncs();   return 64'(mshr[18:16]); endfunction
  function automatic logic [63:0] e_flags(); return 64'(mshr[15:0]);  endfunction
  function automatic logic [63:0] g_val(input int k); return gpr[64*k +: 64]; endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; alloc_v = 0; alloc_lce_id = '0; alloc_paddr = '0; alloc_flags = '0;
    sel_id = '0; field_w_v = '0; flag_w_v = '0; src_a = '0; release_v = 0;
    gpr_w_mask = '0; dir_addr_v = 0; dir_addr_gpr = '0; dir_addr = '0;
  endtask

  initial begin
    idle();
    reset_n = 0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_count", 64'(busy_count), 64'h0);
    check("rst_ready", 64'(alloc_ready), 64'h1);
    check("rst_id", 64'(alloc_id), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_perf", 64'(perf_block_cnt), 64'h0);
    check("rst_gpr3", g_val(3), 64'h0);
    reset_n = 1;

    for (int k = 0; k < 4; k++) begin
      alloc_v = 1; alloc_lce_id = 4'(k+1); alloc_paddr = 40'(256*(k+1)); alloc_flags = 16'(1 << k);
      #1;
      check("alloc_id", 64'(alloc_id), 64'(k));
      tick();
      check("alloc_count", 64'(busy_count), 64'(k+1));
    end
    idle(); #1;
    check("full_busy", 64'(busy), 64'hF);
    check("full_ready", 64'(alloc_ready), 64'h0);
    check("full_count", 64'(busy_count), 64'h4);
    sel_id = 1; #1;
    check("e1_lce", e_lce(), 64'h2);
    check("e1_paddr", e_paddr(), 64'h200);
    check("e1_flags", e_flags(), 64'h2);
    check("e1_way", e_way(), 64'h0);
    check("e1_ncs", e_ncs(), 64'(e_COH_I));

    sel_id = 0; field_w_v[e_mshr_fld_paddr] = 1'b1; src_a = 64'h55AA;
    tick(); idle(); #1;
    check("e0_paddr_wr", e_paddr(), 64'h55AA);
    check("e0_lce_keep", e_lce(), 64'h1);
    field_w_v[e_mshr_fld_way] = 1'b1; field_w_v[e_mshr_fld_ncs] = 1'b1;
    flag_w_v = 16'h0100; src_a = 64'h12B;
    tick(); idle(); #1;
    check("e0_way_wr", e_way(), 64'h2B);
    check("e0_ncs_wr", e_ncs(), 64'h3);
    check("e0_flag_wr", e_flags(), 64'h0101);

    alloc_v = 1; alloc_lce_id = 4'h9; alloc_paddr = 40'h999;
    tick();
    check("full_ign_busy", 64'(busy), 64'hF);
    check("full_ign_count", 64'(busy_count), 64'h4);
    sel_id = 3; #1;
    check("full_ign_e3", e_lce(), 64'h4);

    sel_id = 2; release_v = 1;
    tick(); release_v = 0; #1;
    check("rel_busy", 64'(busy), 64'hB);
    check("rel_count", 64'(busy_count), 64'h3);
    check("rel_id", 64'(alloc_id), 64'h2);
    check("rel_zero", e_paddr(), 64'h0);
    alloc_lce_id = 4'h7; alloc_paddr = 40'h777; alloc_flags = 16'h00F0;
    tick(); idle(); sel_id = 2; #1;
    check("realloc_busy", 64'(busy), 64'hF);
    check("realloc_count", 64'(busy_count), 64'h4);
    check("realloc_lce", e_lce(), 64'h7);
    check("realloc_flags", e_flags(), 64'hF0);

    stall = 1; sel_id = 1; field_w_v[e_mshr_fld_paddr] = 1'b1; src_a = 64'h1234;
    gpr_w_mask = 8'h08; dir_addr_v = 1; dir_addr_gpr = 3; dir_addr = 40'hABC;
    tick(); idle(); sel_id = 1; #1;
    check("stall_paddr", e_paddr(), 64'h200);
    check("stall_gpr3", g_val(3), 64'hABC);
    check("stall_err", 64'(err), 64'h0);
    gpr_w_mask = 8'h30; src_a = 64'hDEAD; dir_addr_v = 1; dir_addr_gpr = 5; dir_addr = 40'h1F;
    tick(); idle(); #1;
    check("gpr4_mask", g_val(4), 64'hDEAD);
    check("gpr5_dir_wins", g_val(5), 64'h1F);
    check("gpr3_keep", g_val(3), 64'hABC);

    sel_id = 1; release_v = 1;
    tick(); idle(); #1;
    check("rel1_busy", 64'(busy), 64'hD);
    check("rel1_err", 64'(err), 64'h0);
    sel_id = 1; field_w_v[e_mshr_fld_lce] = 1'b1; src_a = 64'hF;
    tick(); idle(); sel_id = 1; #1;
    check("nb_wr_lce", e_lce(), 64'h0);
    check("nb_wr_busy", 64'(busy), 64'hD);
    check("nb_wr_err", 64'(err), 64'h1);
    tick();
    check("err_sticky", 64'(err), 64'h1);

    alloc_v = 1; sel_id = 0; field_w_v = 4'hF; src_a = 64'h3; reset_n = 0;
    tick(); idle(); reset_n = 1; #1;
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_count", 64'(busy_count), 64'h0);
    check("mid_rst_err", 64'(err), 64'h0);
    check("mid_rst_gpr5", g_val(5), 64'h0);
    check("mid_rst_perf", 64'(perf_block_cnt), 64'h0);
    check("mid_rst_e0", e_paddr(), 64'h0);

    alloc_v = 1; alloc_paddr = 40'h42;
    for (int c = 0; c < 14; c++) tick();
    idle(); #1;
    check("perf_busy", 64'(busy), 64'hF);
    check("perf_cnt", 64'(perf_block_cnt), perf_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
